// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide sequencer owning the HI/LO pair.
//   One MD-class op is accepted per issue while idle. mult/multu/div/divu
//   compute their result at issue into a pending pair and commit it to HI/LO
//   after a fixed busy window. mthi/mtlo write HI/LO directly at issue.
//   stall holds the pipeline while busy and a later op or mfhi/mflo is
//   present in E.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   op_valid, op_*        MD-class op select (priority mult>multu>div>divu>mthi>mtlo)
//   operand_a/operand_b   rs / rt values, sampled at issue only
//   read_hi/read_lo       E-stage mfhi / mflo
//   stall, busy           hazard stall / op in flight
//   hi, lo, rd_data       architectural HI/LO and mfhi/mflo read data
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        read_hi,
  input  logic        read_lo,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  // Result held between issue and commit; skip marks a divide by zero,
  // which still runs the full window but leaves HI/LO untouched.
  typedef struct packed {
    logic [31:0] phi;
    logic [31:0] plo;
    logic        skip;
  } pend_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        done;
  pend_t       pend;

  // ---- decode (priority chain, gated by op_valid) ----
  logic is_mul, is_div, is_mthi, is_mtlo, is_sgn;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    is_sgn  = 1'b0;
    if (op_valid) begin
      if (op_mult)       begin is_mul = 1'b1; is_sgn = 1'b1; end
      else if (op_multu) begin is_mul = 1'b1; end
      else if (op_div)   begin is_div = 1'b1; is_sgn = 1'b1; end
      else if (op_divu)  begin is_div = 1'b1; end
      else if (op_mthi)  begin is_mthi = 1'b1; end
      else if (op_mtlo)  begin is_mtlo = 1'b1; end
    end
  end

  logic issue;
  assign issue = (state == IDLE) && op_valid;

  // ---- multiply: sign-extend to 64 bits, low 64 bits of the product are
  // correct for both signed and unsigned interpretations ----
  logic [63:0] ext_a, ext_b, prod;
  assign ext_a = {{32{is_sgn & operand_a[31]}}, operand_a};
  assign ext_b = {{32{is_sgn & operand_b[31]}}, operand_b};
  assign prod  = ext_a * ext_b;

  // ---- divide on magnitudes, then restore signs. Quotient negative when
  // signs differ, remainder follows the dividend. 0x80000000/-1 falls out
  // as magnitude 0x80000000 with a positive sign, i.e. LO=0x80000000. ----
  logic        neg_a, neg_b, b_zero;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quo, rem;
  assign neg_a  = is_sgn & operand_a[31];
  assign neg_b  = is_sgn & operand_b[31];
  assign mag_a  = neg_a ? (32'd0 - operand_a) : operand_a;
  assign mag_b  = neg_b ? (32'd0 - operand_b) : operand_b;
  assign b_zero = (operand_b == 32'd0);
  assign div_b  = b_zero ? 32'd1 : mag_b;  // keep the divider defined
  assign q_mag  = mag_a / div_b;
  assign r_mag  = mag_a % div_b;
  assign quo    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
  assign rem    = neg_a ? (32'd0 - r_mag) : r_mag;

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (issue && is_mul) begin
          state_nxt = MULT;
          cnt_nxt   = 4'(MULT_CYCLES);
        end else if (issue && is_div) begin
          state_nxt = DIV;
          cnt_nxt   = 4'(DIV_CYCLES);
        end
      end
      MULT, DIV: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- HI/LO and pending result ----
  // Issue only happens in IDLE and commit only in MULT/DIV, so the two
  // write paths never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      pend <= '0;
    end else begin
      if (issue) begin
        if (is_mul)       pend <= '{phi: prod[63:32], plo: prod[31:0], skip: 1'b0};
        else if (is_div)  pend <= '{phi: rem, plo: quo, skip: b_zero};
        else if (is_mthi) hi   <= operand_a;
        else if (is_mtlo) lo   <= operand_a;
      end
      if (done && !pend.skip) begin
        hi <= pend.phi;
        lo <= pend.plo;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign stall   = busy & (op_valid | read_hi | read_lo);
  assign rd_data = read_hi ? hi : (read_lo ? lo : 32'd0);

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_mult = 1'b0, op_multu = 1'b0, op_div = 1'b0, op_divu = 1'b0;
  logic        op_mthi = 1'b0, op_mtlo = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic        read_hi = 1'b0, read_lo = 1'b0;
  logic        stall, busy;
  logic [31:0] hi, lo, rd_data;

  mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .op_mthi(op_mthi), .op_mtlo(op_mtlo),
    .operand_a(operand_a), .operand_b(operand_b),
    .read_hi(read_hi), .read_lo(read_lo),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;  // reference architectural HI/LO

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // bit order: {mtlo, mthi, divu, div, multu, mult}
  task automatic set_ops(input logic [5:0] bits, input logic v);
    {op_mtlo, op_mthi, op_divu, op_div, op_multu, op_mult} = bits;
    op_valid = v;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition.
  task automatic model(input int kind, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    case (kind)
      0: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0];
      end
      1: begin
        p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0];
      end
      2: if (b != 0) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
      end
      3: if (b != 0) begin
        sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
        m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
      end
      4: m_hi = a;
      default: m_lo = a;
    endcase
  endtask

  // Issue one op (plus optional lower-priority noise bits), scramble operands
  // after issue, check the busy window, stall and final HI/LO/rd_data.
  task automatic run_op(input int kind, input logic [5:0] extra,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic rh, input logic rl);
    int n;
    @(posedge clk); #1;
    set_ops(6'(1 << kind) | extra, 1'b1);
    operand_a = a; operand_b = b; read_hi = rh; read_lo = rl;
    @(negedge clk);
    chk("issue_busy", 32'(busy), 32'd0);
    chk("issue_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    set_ops(6'd0, 1'b0);
    operand_a = $urandom; operand_b = $urandom;
    model(kind, a, b);
    n = (kind < 2) ? MC : ((kind < 4) ? DC : 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("win_busy", 32'(busy), 32'd1);
      chk("win_stall", 32'(stall), 32'(rh | rl));
    end
    @(negedge clk);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_hi", hi, m_hi);
    chk("done_lo", lo, m_lo);
    chk("done_rd", rd_data, rh ? m_hi : (rl ? m_lo : 32'd0));
    read_hi = 1'b0; read_lo = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      3: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;

    // ---- reset mid-MULT abandons the result ----
    @(posedge clk); #1;
    set_ops(6'b000001, 1'b1); operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk); #1;
    set_ops(6'd0, 1'b0); read_lo = 1'b1;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    read_lo = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (MC + 2) @(posedge clk);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    // ---- directed cases ----
    run_op(0, 6'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
    chk("smul_hi", hi, 32'hFFFF_FFFF);
    chk("smul_lo", lo, 32'hFFFF_FFFA);
    run_op(1, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("umul_hi", hi, 32'hFFFF_FFFE);
    chk("umul_lo", lo, 32'h0000_0001);
    run_op(2, 6'd0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("sdiv_hi", hi, 32'hFFFF_FFFF);
    chk("sdiv_lo", lo, 32'hFFFF_FFFD);
    run_op(4, 6'd0, 32'h0000_00AA, 32'd0, 1'b0, 1'b0);
    run_op(5, 6'd0, 32'h0000_00BB, 32'd0, 1'b0, 1'b0);
    run_op(3, 6'd0, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
    chk("dz_hi", hi, 32'h0000_00AA);
    chk("dz_lo", lo, 32'h0000_00BB);
    run_op(2, 6'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_lo", lo, 32'h8000_0000);

    // ---- op bits without op_valid are ignored ----
    @(posedge clk); #1;
    set_ops(6'b000001, 1'b0); operand_a = 32'd9; operand_b = 32'd9;
    @(posedge clk); #1; set_ops(6'd0, 1'b0);
    @(negedge clk);
    chk("novalid_busy", 32'(busy), 32'd0);
    chk("novalid_lo", lo, m_lo);

    // ---- mult followed immediately by mthi: held by stall ----
    @(posedge clk); #1;
    set_ops(6'b000001, 1'b1); operand_a = 32'd2; operand_b = 32'd3;
    @(posedge clk); #1;
    set_ops(6'b010000, 1'b1); operand_a = 32'h55; operand_b = 32'd0;
    for (int i = 0; i < MC; i++) begin
      @(negedge clk);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_stall", 32'(stall), 32'd1);
    end
    @(negedge clk);
    chk("b2b_done_stall", 32'(stall), 32'd0);
    chk("b2b_done_hi", hi, 32'd0);
    chk("b2b_done_lo", lo, 32'd6);
    @(posedge clk); #1; set_ops(6'd0, 1'b0);
    @(negedge clk);
    chk("b2b_mthi_busy", 32'(busy), 32'd0);
    chk("b2b_mthi_hi", hi, 32'h55);
    chk("b2b_mthi_lo", lo, 32'd6);
    m_hi = 32'h55; m_lo = 32'd6;

    // ---- randomized ops against the reference ----
    for (int t = 0; t < 40; t++) begin
      int          k;
      logic [31:0] a, b;
      logic [5:0]  ex;
      k  = $urandom_range(0, 5);
      a  = pick();
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      ex = 6'($urandom) & ~6'((2 << k) - 1);  // only lower-priority bits
      run_op(k, ex, a, b, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
